lcd_text_seq: RTL and testbench

- Parametrised successor to the single-line LCD character sequencer.
- Buffers UART RX bytes in a small FIFO, runs the HD44780 power-on/init sequence, then translates bytes into LCD command/data words.
- Supports COLS x ROWS geometry, CR clear, LF newline, backspace, and wrap to the next row or a clear-and-home.
- Sits between the UART receiver and the LCD bus driver/delay timer; only one LCD operation is outstanding at a time.

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_text_seq_fifo.sv | 54 +++++
 rtl/lcd_text_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_lcd_text_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 command/character constants and sequencer types
// for the UART-to-LCD text path.
package lcd_pkg;

  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP  = 8'h0D;
  localparam logic [7:0] FSET_1L   = 8'h30;
  localparam logic [7:0] FSET_2L   = 8'h38;
  localparam logic [7:0] CUR_LEFT  = 8'h10;
  localparam logic [7:0] ROW1_ADDR = 8'hC0;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  localparam int RS_BIT = 9;
  localparam int RW_BIT = 8;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [9:0] word;
    logic       long_dly;
  } lcd_op_t;

  function automatic logic [9:0] cmd_w(input logic [7:0] c);
    logic [9:0] w;
    w = {2'b00, c};
    w[RW_BIT] = 1'b0;
    return w;
  endfunction

  function automatic logic [9:0] data_w(input logic [7:0] c);
    logic [9:0] w;
    w = cmd_w(c);
    w[RS_BIT] = 1'b1;
    return w;
  endfunction

  function automatic lcd_op_t mk_op(input logic [9:0] w,
                                    input logic       lng);
    lcd_op_t o;
    o.word     = w;
    o.long_dly = lng;
    return o;
  endfunction

endpackage

// File: rtl/lcd_text_seq_fifo.sv
// Small synchronous FIFO holding received UART bytes until the
// sequencer is free; pushes into a full FIFO are refused.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_text_seq.sv
// Power-on/init sequencer plus byte-to-LCD translator with cursor
// tracking; one LCD operation in flight, gated by an external timer.
module lcd_text_seq
  import lcd_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DLY_W      = 17,
  parameter int SHORT_DLY  = 2000,
  parameter int LONG_DLY   = 76000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    delay_done,
  output logic                    delay_start,
  output logic [DLY_W-1:0]        delay_value,
  output logic                    lcd_strobe,
  output logic [9:0]              lcd_word,
  output logic                    init_done,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic                    cur_row,
  output logic                    overflow
);

  localparam int CW = $clog2(COLS);
  localparam logic [DLY_W-1:0] LONG_V  = DLY_W'(LONG_DLY);
  localparam logic [DLY_W-1:0] SHORT_V = DLY_W'(SHORT_DLY);
  localparam logic [7:0] FSET = (ROWS == 2) ? FSET_2L : FSET_1L;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic TWO_ROWS = (ROWS == 2);

  state_e           state_q, state_d;
  lcd_op_t          ops_q [4];
  lcd_op_t          ops_d [4];
  logic [1:0]       step_q, step_d;
  logic [1:0]       nops_q, nops_d;
  logic [2:0]       init_q, init_d;
  logic [CW-1:0]    col_q, col_d;
  logic             row_q, row_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ds_q, ds_d;
  logic             stb_q, stb_d;
  logic [DLY_W-1:0] dv_q, dv_d;
  logic [9:0]       word_q, word_d;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_byte;
  logic       iss;
  lcd_op_t    iss_op;
  logic       is_print, is_clr, wrap_row, at_end;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_valid),
    .wdata(rx_data),
    .pop  (fifo_pop),
    .rdata(fifo_byte),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  function automatic lcd_op_t init_op(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return mk_op(cmd_w(FSET), 1'b0);
      3'd3:             return mk_op(cmd_w(CMD_DISP), 1'b1);
      3'd4:             return mk_op(cmd_w(CMD_CLR), 1'b1);
      default:          return mk_op(cmd_w(CMD_ENTRY), 1'b0);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    ops_d    = ops_q;
    step_d   = step_q;
    nops_d   = nops_q;
    init_d   = init_q;
    col_d    = col_q;
    row_d    = row_q;
    pend_d   = pend_q;
    done_d   = done_q;
    word_d   = word_q;
    dv_d     = dv_q;
    ds_d     = 1'b0;
    stb_d    = 1'b0;
    fifo_pop = 1'b0;
    iss      = 1'b0;
    iss_op   = '0;
    // A refused push is sticky even if a pop frees space this cycle.
    ovf_d    = ovf_q | (rx_valid & fifo_full);

    is_print = (fifo_byte >= 8'h20) && (fifo_byte <= 8'h7E);
    wrap_row = TWO_ROWS && !row_q;
    is_clr   = (fifo_byte == CH_CR) ||
               ((fifo_byte == CH_LF) && !wrap_row);
    at_end   = (col_q == LAST_COL);

    unique case (state_q)
      ST_PWR: begin
        ds_d    = 1'b1;
        dv_d    = LONG_V;
        init_d  = '0;
        state_d = ST_WAIT;
      end
      ST_INIT: begin
        iss     = 1'b1;
        iss_op  = init_op(init_q);
        init_d  = init_q + 3'd1;
        state_d = ST_WAIT;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          nops_d   = 2'd0;
          unique case (1'b1)
            is_clr: begin
              ops_d[0] = mk_op(cmd_w(CMD_CLR), 1'b1);
              nops_d   = 2'd1;
              col_d    = '0;
              row_d    = 1'b0;
              pend_d   = 1'b0;
            end
            (fifo_byte == CH_LF) && !is_clr: begin
              ops_d[0] = mk_op(cmd_w(ROW1_ADDR), 1'b0);
              nops_d   = 2'd1;
              col_d    = '0;
              row_d    = 1'b1;
            end
            (fifo_byte == CH_BS) && (col_q != '0): begin
              ops_d[0] = mk_op(cmd_w(CUR_LEFT), 1'b0);
              ops_d[1] = mk_op(data_w(8'h20), 1'b0);
              ops_d[2] = mk_op(cmd_w(CUR_LEFT), 1'b0);
              nops_d   = 2'd3;
              col_d    = col_q - CW'(1);
            end
            is_print && pend_q: begin
              ops_d[0] = mk_op(cmd_w(CMD_CLR), 1'b1);
              ops_d[1] = mk_op(data_w(fifo_byte), 1'b0);
              nops_d   = 2'd2;
              col_d    = CW'(1);
              row_d    = 1'b0;
              pend_d   = 1'b0;
            end
            is_print && !pend_q && at_end && wrap_row: begin
              ops_d[0] = mk_op(data_w(fifo_byte), 1'b0);
              ops_d[1] = mk_op(cmd_w(ROW1_ADDR), 1'b0);
              nops_d   = 2'd2;
              col_d    = '0;
              row_d    = 1'b1;
            end
            is_print && !pend_q && at_end && !wrap_row: begin
              // Cursor parks on the last cell until the next printable.
              ops_d[0] = mk_op(data_w(fifo_byte), 1'b0);
              nops_d   = 2'd1;
              pend_d   = 1'b1;
            end
            is_print && !pend_q && !at_end: begin
              ops_d[0] = mk_op(data_w(fifo_byte), 1'b0);
              nops_d   = 2'd1;
              col_d    = col_q + CW'(1);
            end
            default: ;
          endcase
          if (nops_d != 2'd0) begin
            iss     = 1'b1;
            iss_op  = ops_d[0];
            step_d  = 2'd1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_ISSUE: begin
        iss     = 1'b1;
        iss_op  = ops_q[step_q];
        step_d  = step_q + 2'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (delay_done) begin
          if (!done_q) begin
            if (init_q == 3'd6) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_INIT;
            end
          end else if (step_q < nops_q) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWR;
    endcase

    if (iss) begin
      ds_d   = 1'b1;
      stb_d  = 1'b1;
      word_d = iss_op.word;
      dv_d   = iss_op.long_dly ? LONG_V : SHORT_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PWR;
      for (int i = 0; i < 4; i++) ops_q[i] <= '0;
      step_q  <= '0;
      nops_q  <= '0;
      init_q  <= '0;
      col_q   <= '0;
      row_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ds_q    <= 1'b0;
      stb_q   <= 1'b0;
      dv_q    <= LONG_V;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      step_q  <= step_d;
      nops_q  <= nops_d;
      init_q  <= init_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ds_q    <= ds_d;
      stb_q   <= stb_d;
      dv_q    <= dv_d;
      word_q  <= word_d;
    end
  end

  assign delay_start = ds_q;
  assign delay_value = dv_q;
  assign lcd_strobe  = stb_q;
  assign lcd_word    = word_q;
  assign init_done   = done_q;
  assign cur_col     = col_q;
  assign cur_row     = row_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_lcd_text_seq.sv
// Bench for lcd_text_seq: acts as the delay timer, logs every issued
// word and compares the stream against a byte-level display model.
module tb_lcd_text_seq;

  localparam int COLS  = 16;
  localparam int ROWS  = 2;
  localparam int DEPTH = 8;
  localparam int LONG  = 76000;
  localparam int SHORT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        delay_done;
  logic        delay_start;
  logic [16:0] delay_value;
  logic        lcd_strobe;
  logic [9:0]  lcd_word;
  logic        init_done;
  logic [3:0]  cur_col;
  logic        cur_row;
  logic        overflow;

  always #5 clk = ~clk;

  lcd_text_seq #(
    .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH), .DLY_W(17),
    .SHORT_DLY(SHORT), .LONG_DLY(LONG)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .delay_done(delay_done), .delay_start(delay_start),
    .delay_value(delay_value), .lcd_strobe(lcd_strobe),
    .lcd_word(lcd_word), .init_done(init_done), .cur_col(cur_col),
    .cur_row(cur_row), .overflow(overflow)
  );

  typedef logic [7:0] bq_t[$];

  logic [28:0] ev_q[$];
  logic [28:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tmr_cnt = 0;
  int done_cnt = 0;
  bit busy = 1'b0;
  int m_col, m_row;
  bit m_pend, m_ovf;
  bq_t q;
  logic [7:0] b;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timer stand-in and word logger; stray delay_done pulses land only
  // while no timer is running, so they must be ignored by the DUT.
  always @(negedge clk) begin
    delay_done = 1'b0;
    if (rst) begin
      tmr_cnt  = 0;
      busy     = 1'b0;
      done_cnt = 0;
    end else begin
      if (delay_start || lcd_strobe)
        ev_q.push_back({delay_start, lcd_strobe, lcd_word, delay_value});
      if (delay_start) begin
        chk("single_outstanding", 32'(busy), 32'd0);
        busy    = 1'b1;
        tmr_cnt = $urandom_range(2, 5);
      end else if (tmr_cnt > 0) begin
        tmr_cnt--;
        if (tmr_cnt == 0) begin
          delay_done = 1'b1;
          busy       = 1'b0;
          done_cnt++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        delay_done = 1'b1;
      end
    end
  end

  function automatic void ex(input logic [9:0] w, input bit lng);
    exp_q.push_back({1'b1, 1'b1, w, lng ? 17'(LONG) : 17'(SHORT)});
  endfunction

  function automatic void exp_init();
    exp_q.push_back({1'b1, 1'b0, 10'h000, 17'(LONG)});
    ex(10'h038, 0); ex(10'h038, 0); ex(10'h038, 0);
    ex(10'h00D, 1); ex(10'h001, 1); ex(10'h006, 0);
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    if (c == 8'h0D || (c == 8'h0A && m_row != 0)) begin
      ex(10'h001, 1);
      m_col = 0; m_row = 0; m_pend = 0;
    end else if (c == 8'h0A) begin
      ex(10'h0C0, 0);
      m_col = 0; m_row = 1;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        ex(10'h010, 0); ex(10'h220, 0); ex(10'h010, 0);
        m_col--;
      end
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      if (m_pend) begin
        ex(10'h001, 1);
        m_col = 0; m_row = 0; m_pend = 0;
      end
      ex({2'b10, c}, 0);
      m_col++;
      if (m_col == COLS) begin
        if (m_row < ROWS - 1) begin
          ex(10'h0C0, 0);
          m_row++; m_col = 0;
        end else begin
          m_pend = 1;
        end
      end
    end
  endfunction

  task automatic push_byte(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_delay_start"}, 32'(delay_start), 32'd0);
    chk({tag, "_strobe"}, 32'(lcd_strobe), 32'd0);
    chk({tag, "_word"}, 32'(lcd_word), 32'h000);
    chk({tag, "_value"}, 32'(delay_value), 32'(LONG));
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_col"}, 32'(cur_col), 32'd0);
    chk({tag, "_row"}, 32'(cur_row), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic settle(input string tag);
    int k;
    logic [31:0] o;
    k = 0;
    while ((ev_q.size() < exp_q.size() || busy) && k < 3000) begin
      @(posedge clk); #2;
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
    repeat (15) begin @(posedge clk); #2; end
    chk({tag, "_nwords"}, 32'(ev_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      o = 'x;
      if (i < ev_q.size()) o = 32'(ev_q[i]);
      chk($sformatf("%s_word%0d", tag, i), o, 32'(exp_q[i]));
    end
    ev_q.delete();
    exp_q.delete();
    if (m_col < COLS) chk({tag, "_col"}, 32'(cur_col), 32'(m_col));
    chk({tag, "_row"}, 32'(cur_row), 32'(m_row));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic send(input bq_t s, input string tag);
    foreach (s[i]) begin
      push_byte(s[i]);
      model_byte(s[i]);
      if (i % 8 == 7 || i == s.size() - 1) settle(tag);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; delay_done = 1'b0;
    m_col = 0; m_row = 0; m_pend = 0; m_ovf = 0;
    repeat (3) @(posedge clk); #2;
    check_reset("reset");
    rst = 1'b0;
    exp_init();

    // Nine bytes during init: the ninth finds the FIFO full.
    q = {8'h41, 8'h42, 8'h08, 8'h0D, 8'h48, 8'h49, 8'h78, 8'h79, 8'h7A};
    foreach (q[i]) begin
      push_byte(q[i]);
      if (i < DEPTH) model_byte(q[i]);
    end
    m_ovf = 1;
    n = 0;
    while (ev_q.size() < 7 && n < 500) begin @(posedge clk); #2; n++; end
    chk("init_six_words_timeout", 32'(n < 500), 32'd1);
    chk("init_done_before_last_done", 32'(init_done), 32'd0);
    n = 0;
    while (done_cnt < 7 && n < 500) begin @(posedge clk); #2; n++; end
    chk("init_last_done_timeout", 32'(n < 500), 32'd1);
    chk("init_done_rise", 32'(init_done), 32'd1);
    settle("init_fifo");

    send({8'h0D, 8'h48, 8'h49}, "hi");
    send({8'h0D, 8'h41, 8'h42, 8'h08}, "bs");
    send({8'h08}, "bs_to0");
    send({8'h08}, "bs_col0");

    q = {8'h0D};
    repeat (17) q.push_back(8'($urandom_range(32, 126)));
    send(q, "wrap_row1");

    q = {8'h0D};
    repeat (32) q.push_back(8'($urandom_range(32, 126)));
    q.push_back(8'h41);
    send(q, "fill_home");

    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 9))
          6:       b = 8'h0D;
          7:       b = 8'h0A;
          8:       b = m_pend ? 8'h61 : 8'h08;
          9:       b = ($urandom_range(0, 1) == 0) ? 8'h1B : 8'h9F;
          default: b = 8'($urandom_range(32, 126));
        endcase
        push_byte(b);
        model_byte(b);
      end
      settle("random");
    end

    // Reset while a write is waiting on the timer, with bytes queued.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    n = 0;
    while (!(busy && ev_q.size() > 0) && n < 200) begin
      @(posedge clk); #2; n++;
    end
    chk("mid_wait_reach", 32'(n < 200), 32'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    check_reset("mid_reset");
    @(posedge clk); #2;
    ev_q.delete(); exp_q.delete();
    m_col = 0; m_row = 0; m_pend = 0; m_ovf = 0;
    rst = 1'b0;
    exp_init();
    settle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
